result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 23 ++
 rtl/result_collector_if.sv | 28 ++
 rtl/result_collector_sat_counter.sv | 40 ++++
 rtl/result_collector.sv | 112 +++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared definitions for the execution unit and the result collector.
//   - Status flag bit positions (OVF, ERROR, EVEN, SINGLE)
//   - Result word width, statistics counter width
//   - Entry type {data, status} as stored in the collector FIFO
package result_collector_pkg;

  localparam int unsigned DataW = 8;  // execution unit operand/result width
  localparam int unsigned CntW  = 8;  // statistics counter width

  localparam int unsigned StatusW         = 4;
  localparam int unsigned StatusOvfBit    = 3;
  localparam int unsigned StatusErrBit    = 2;
  localparam int unsigned StatusEvenBit   = 1;
  localparam int unsigned StatusSingleBit = 0;

  typedef logic [StatusW-1:0] status_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    status_t          status;
  } entry_t;

endpackage

// File: rtl/result_collector_if.sv
// Result handshake bundle between an execution unit / downstream consumer and the collector.
//   Upstream:   i_valid, i_data, i_status -> collector; o_ready <- collector
//   Downstream: o_valid, o_data, o_status <- collector; i_ready -> collector
// master: the environment driving results and accepting entries; slave: the collector.
interface result_collector_if
  import result_collector_pkg::*;
#(
  parameter int unsigned BITS = DataW
);
  logic            i_valid;
  logic [BITS-1:0] i_data;
  status_t         i_status;
  logic            o_ready;
  logic            o_valid;
  logic [BITS-1:0] o_data;
  status_t         o_status;
  logic            i_ready;

  modport master (
    output i_valid, i_data, i_status, i_ready,
    input  o_ready, o_valid, o_data, o_status
  );

  modport slave (
    input  i_valid, i_data, i_status, i_ready,
    output o_ready, o_valid, o_data, o_status
  );
endinterface

// File: rtl/result_collector_sat_counter.sv
// Saturating event counter.
//   i_clk   clock, rising edge
//   i_rst   synchronous active-low reset
//   clr_i   synchronous clear, wins over inc_i
//   inc_i   count one event (ignored once at all-ones)
//   cnt_o   current count
module sat_counter
  import result_collector_pkg::*;
#(
  parameter int unsigned W = CntW
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/result_collector.sv
// Result collector: DEPTH-entry FIFO of {data, status} words from the execution unit, with
// error/overflow/drop statistics and a sticky error flag.
//   i_clk, i_rst     clock (rising edge), synchronous active-low reset
//   bus_io           result handshake (slave side): upstream write, downstream read
//   i_clr            synchronous clear of counters and sticky flag (FIFO untouched)
//   o_count          occupancy
//   o_err_cnt        accepted ERROR-flagged writes (saturating)
//   o_ovf_cnt        accepted OVF-flagged writes (saturating)
//   o_drop_cnt       results offered while full (saturating)
//   o_sticky_err     set by any accepted ERROR-flagged write
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned BITS  = DataW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  result_collector_if.slave       bus_io,
  input  logic                    i_clr,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [CntW-1:0]         o_err_cnt,
  output logic [CntW-1:0]         o_ovf_cnt,
  output logic [CntW-1:0]         o_drop_cnt,
  output logic                    o_sticky_err
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              sticky_q, sticky_d;
  entry_t            mem_q [DEPTH];
  entry_t            head;

  logic ready, valid, wr_en, rd_en;
  logic err_inc, ovf_inc, drop_inc;

  always_comb begin
    ready    = count_q < CountW'(DEPTH);
    valid    = count_q != '0;
    // Full blocks the write even when a read frees a slot this cycle.
    wr_en    = bus_io.i_valid && ready;
    rd_en    = valid && bus_io.i_ready;
    drop_inc = bus_io.i_valid && !ready;
    err_inc  = wr_en && bus_io.i_status[StatusErrBit];
    ovf_inc  = wr_en && bus_io.i_status[StatusOvfBit];

    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CountW'(wr_en) - CountW'(rd_en);
    sticky_d = i_clr ? 1'b0 : (sticky_q | err_inc);
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    bus_io.o_ready  = ready;
    bus_io.o_valid  = valid;
    bus_io.o_data   = valid ? BITS'(head.data) : '0;
    bus_io.o_status = valid ? head.status : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: occupancy gates visibility of every slot.
  always_ff @(posedge i_clk) begin
    if (i_rst && wr_en) begin
      mem_q[wr_ptr_q] <= '{data: DataW'(bus_io.i_data), status: bus_io.i_status};
    end
  end

  sat_counter #(.W(CntW)) u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (i_clr),
    .inc_i (err_inc),
    .cnt_o (o_err_cnt)
  );

  sat_counter #(.W(CntW)) u_ovf_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (i_clr),
    .inc_i (ovf_inc),
    .cnt_o (o_ovf_cnt)
  );

  sat_counter #(.W(CntW)) u_drop_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (i_clr),
    .inc_i (drop_inc),
    .cnt_o (o_drop_cnt)
  );

  assign o_count      = count_q;
  assign o_sticky_err = sticky_q;

endmodule
